bw_mul_acc: RTL and testbench

Frame accumulator that sits directly downstream of the combinational 8-bit Baugh-Wooley signed multiplier. It consumes the multiplier's signed product stream over a valid/ready handshake and sums a programmable number of products into a wider signed accumulator. Each finished frame is presented on a valid/ready output, with an overflow flag, to the user-project register interface.

---
 rtl/bw_acc_pkg.sv | 30 +++
 rtl/bw_acc_add.sv | 40 ++++
 rtl/bw_mul_acc.sv | 128 ++++++++++++
 tb/tb_bw_mul_acc.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bw_acc_pkg.sv
// rtl/bw_acc_pkg.sv - shared types and helpers for the bw_mul_acc frame accumulator
//
// Contents:
//   state_e       : frame FSM states (IDLE, ACC, HOLD)
//   sat_max_f     : bit pattern of the most positive value of an aw-bit signed number
//   sat_min_f     : bit pattern of the most negative value of an aw-bit signed number
//   ovf_detect    : signed-addition overflow from operand and sum sign bits
package bw_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Returned 64 bits wide; callers truncate to their accumulator width.
    function automatic logic [63:0] sat_max_f(input int aw);
        return (64'd1 << (aw - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min_f(input int aw);
        return 64'd1 << (aw - 1);
    endfunction

    // Overflow only when both operands share a sign and the sum's sign differs.
    function automatic logic ovf_detect(input logic sign_a, input logic sign_b, input logic sign_s);
        return (sign_a == sign_b) && (sign_s != sign_a);
    endfunction

endpackage

// File: rtl/bw_acc_add.sv
// rtl/bw_acc_add.sv - sign-extend-and-add stage with overflow detect and optional saturation
//
// Ports:
//   acc_i  : AW-bit signed running sum
//   prod_i : PW-bit signed product, sign-extended to AW before the add
//   sum_o  : AW-bit result (wrapped, or saturated when BW_ACC_SAT_EN is defined)
//   ovf_o  : this addition overflowed AW bits
//
// Macro BW_ACC_SAT_EN: when defined, an overflowing sum is clamped to the
// extreme value in the direction of the operands; otherwise it wraps.
module bw_acc_add
    import bw_acc_pkg::*;
#(
    parameter int PW = 8,
    parameter int AW = 20
) (
    input  logic [AW-1:0] acc_i,
    input  logic [PW-1:0] prod_i,
    output logic [AW-1:0] sum_o,
    output logic          ovf_o
);

    logic [AW-1:0] prod_sext;
    logic [AW-1:0] raw_sum;

    assign prod_sext = {{(AW - PW){prod_i[PW-1]}}, prod_i};
    assign raw_sum   = acc_i + prod_sext;
    assign ovf_o     = ovf_detect(acc_i[AW-1], prod_sext[AW-1], raw_sum[AW-1]);

`ifdef BW_ACC_SAT_EN
    localparam logic [AW-1:0] SAT_MAX = AW'(sat_max_f(AW));
    localparam logic [AW-1:0] SAT_MIN = AW'(sat_min_f(AW));

    // On overflow both operands share a sign; acc_i's sign picks the rail.
    assign sum_o = ovf_o ? (acc_i[AW-1] ? SAT_MIN : SAT_MAX) : raw_sum;
`else
    assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/bw_mul_acc.sv
// rtl/bw_mul_acc.sv - frame accumulator for the Baugh-Wooley multiplier product stream
//
// Ports:
//   wb_clk_i      : clock, rising edge
//   wb_rst_n_i    : asynchronous active-low reset
//   prod_i        : PW-bit signed product
//   prod_valid_i  : product valid
//   prod_ready_o  : product accepted this cycle (decoded from state only)
//   len_i         : products per frame, sampled on the first product; 0 means 1
//   clear_i       : synchronous abort/clear, highest priority
//   acc_o         : AW-bit signed frame result
//   acc_valid_o   : frame result available
//   acc_ready_i   : consumer takes the result
//   ovf_o         : sticky overflow for the current frame
//
// Macro BW_ACC_SAT_EN: selects saturating instead of wrapping accumulation.
module bw_mul_acc
    import bw_acc_pkg::*;
#(
    parameter int PW    = 8,
    parameter int AW    = 20,
    parameter int LEN_W = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic [PW-1:0]    prod_i,
    input  logic             prod_valid_i,
    output logic             prod_ready_o,
    input  logic [LEN_W-1:0] len_i,
    input  logic             clear_i,
    output logic [AW-1:0]    acc_o,
    output logic             acc_valid_o,
    input  logic             acc_ready_i,
    output logic             ovf_o
);

    state_e           state_q;
    logic [AW-1:0]    acc_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             ovf_q;
    logic             valid_q;

    logic [AW-1:0]    prod_sext;
    logic [AW-1:0]    add_sum_d;
    logic             add_ovf_d;
    logic [LEN_W-1:0] cnt_d;
    logic [LEN_W-1:0] len_d;
    logic             prod_xfer;

    assign prod_ready_o = (state_q != ST_HOLD);
    assign prod_xfer    = prod_valid_i && prod_ready_o;
    assign prod_sext    = {{(AW - PW){prod_i[PW-1]}}, prod_i};
    assign cnt_d        = cnt_q + LEN_W'(1);
    assign len_d        = (len_i == '0) ? LEN_W'(1) : len_i;

    bw_acc_add #(
        .PW (PW),
        .AW (AW)
    ) u_add (
        .acc_i  (acc_q),
        .prod_i (prod_i),
        .sum_o  (add_sum_d),
        .ovf_o  (add_ovf_d)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            // Abort wins over any handshake; a coincident product is dropped.
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (prod_xfer) begin
                        acc_q <= prod_sext;
                        cnt_q <= LEN_W'(1);
                        len_q <= len_d;
                        ovf_q <= 1'b0;
                        if (len_d == LEN_W'(1)) begin
                            state_q <= ST_HOLD;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (prod_xfer) begin
                        acc_q <= add_sum_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_q | add_ovf_d;
                        if (cnt_d == len_q) begin
                            state_q <= ST_HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // acc_q is left alone so the last result stays visible.
                    if (acc_ready_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign acc_o       = acc_q;
    assign acc_valid_o = valid_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_bw_mul_acc.sv
// tb/tb_bw_mul_acc.sv - self-checking bench for bw_mul_acc with a frame-level reference model
module tb_bw_mul_acc;

    localparam int PW     = 8;
    localparam int AW     = 10;
    localparam int LEN_W  = 8;
    localparam int AMAX   = 2 ** (AW - 1) - 1;
    localparam int AMIN   = -(2 ** (AW - 1));
    localparam int ARANGE = 2 ** AW;
`ifdef BW_ACC_SAT_EN
    localparam int OVF_EXP = 511;
`else
    localparam int OVF_EXP = -389;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [PW-1:0]    prod = '0;
    logic             prod_valid = 1'b0;
    logic             prod_ready;
    logic [LEN_W-1:0] len = '0;
    logic             clear = 1'b0;
    logic [AW-1:0]    acc;
    logic             acc_valid;
    logic             acc_ready = 1'b1;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;

    bw_mul_acc #(
        .PW    (PW),
        .AW    (AW),
        .LEN_W (LEN_W)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_n_i   (rst_n),
        .prod_i       (prod),
        .prod_valid_i (prod_valid),
        .prod_ready_o (prod_ready),
        .len_i        (len),
        .clear_i      (clear),
        .acc_o        (acc),
        .acc_valid_o  (acc_valid),
        .acc_ready_i  (acc_ready),
        .ovf_o        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: unbounded integer sum, folded back into AW bits
    // only when it leaves the representable range.
    int m_acc = 0, m_cnt = 0, m_len = 0, m_p = 0, m_s = 0;
    bit m_ovf = 0, m_valid = 0, m_inframe = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 0; m_cnt = 0; m_len = 0; m_ovf = 0; m_valid = 0; m_inframe = 0;
        end else if (clear) begin
            m_acc = 0; m_cnt = 0; m_ovf = 0; m_valid = 0; m_inframe = 0;
        end else if (m_valid) begin
            if (acc_ready) begin
                m_valid = 0;
                m_inframe = 0;
            end
        end else if (prod_valid) begin
            m_p = $signed(prod);
            if (!m_inframe) begin
                m_acc = m_p;
                m_cnt = 1;
                m_len = (len == 0) ? 1 : int'(len);
                m_ovf = 0;
                m_inframe = 1;
            end else begin
                m_s = m_acc + m_p;
                if (m_s > AMAX || m_s < AMIN) begin
                    m_ovf = 1;
`ifdef BW_ACC_SAT_EN
                    m_s = (m_s > AMAX) ? AMAX : AMIN;
`else
                    m_s = (m_s > AMAX) ? m_s - ARANGE : m_s + ARANGE;
`endif
                end
                m_acc = m_s;
                m_cnt++;
            end
            if (m_cnt == m_len) m_valid = 1;
        end
    end

    always @(negedge clk) begin
        chk("model acc_o", $signed(acc), m_acc);
        chk("model acc_valid_o", int'(acc_valid), int'(m_valid));
        chk("model ovf_o", int'(ovf), int'(m_ovf));
        chk("model prod_ready_o", int'(prod_ready), int'(!m_valid));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one product and returns 1 time unit after the edge that took it.
    task automatic send(input int p);
        bit ok;
        bit rdy;
        ok = 0;
        prod = PW'(p);
        prod_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rdy = prod_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        prod_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send timeout: product %0d not accepted within 50 cycles", p);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset acc_o", $signed(acc), 0);
        chk("reset acc_valid_o", int'(acc_valid), 0);
        chk("reset ovf_o", int'(ovf), 0);
        chk("reset prod_ready_o", int'(prod_ready), 1);

        // Basic frame: 10 - 3 + 127 - 128 = 6, valid for exactly one cycle.
        len = 8'd4;
        send(10); send(-3); send(127); send(-128);
        chk("basic acc_o", $signed(acc), 6);
        chk("basic ovf_o", int'(ovf), 0);
        chk("basic valid after last", int'(acc_valid), 1);
        idle(1);
        chk("basic valid one cycle", int'(acc_valid), 0);

        // Length 0 and 1 both mean a single-product frame.
        len = 8'd0;
        send(-5);
        chk("len0 acc_o", $signed(acc), -5);
        chk("len0 valid", int'(acc_valid), 1);
        idle(1);
        len = 8'd1;
        send(-5);
        chk("len1 acc_o", $signed(acc), -5);
        chk("len1 valid", int'(acc_valid), 1);
        idle(1);

        // Backpressure with random input gaps.
        acc_ready = 1'b0;
        len = 8'd3;
        for (int v = 1; v <= 3; v++) begin
            idle(int'($urandom_range(0, 2)));
            send(v);
        end
        repeat (5) begin
            chk("hold acc_o", $signed(acc), 6);
            chk("hold prod_ready_o", int'(prod_ready), 0);
            chk("hold acc_valid_o", int'(acc_valid), 1);
            idle(1);
        end
        acc_ready = 1'b1;
        idle(1);
        chk("post handshake valid", int'(acc_valid), 0);
        chk("post handshake ready", int'(prod_ready), 1);

        // Overflow: five products of 127 in a 10-bit accumulator.
        len = 8'd5;
        repeat (5) send(127);
        chk("ovf acc_o", $signed(acc), OVF_EXP);
        chk("ovf ovf_o", int'(ovf), 1);
        len = 8'd2;
        send(1);
        chk("ovf cleared on load", int'(ovf), 0);
        send(2);
        chk("after ovf acc_o", $signed(acc), 3);
        idle(1);

        // Clear mid-frame with a coincident product.
        len = 8'd4;
        send(5); send(6);
        prod = PW'(7);
        prod_valid = 1'b1;
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        prod_valid = 1'b0;
        chk("clear acc_o", $signed(acc), 0);
        chk("clear valid", int'(acc_valid), 0);
        chk("clear ready", int'(prod_ready), 1);
        len = 8'd1;
        send(7);
        chk("after clear acc_o", $signed(acc), 7);
        idle(1);

        // Clear in HOLD discards the result without a handshake.
        acc_ready = 1'b0;
        send(9);
        chk("hold before clear", int'(acc_valid), 1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("clear in hold valid", int'(acc_valid), 0);
        chk("clear in hold acc_o", $signed(acc), 0);
        acc_ready = 1'b1;

        // Asynchronous reset between edges, mid-frame.
        len = 8'd4;
        send(3); send(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst acc_o", $signed(acc), 0);
        chk("async rst valid", int'(acc_valid), 0);
        chk("async rst ovf_o", int'(ovf), 0);
        chk("async rst ready", int'(prod_ready), 1);
        idle(2);
        rst_n = 1'b1;
        chk("after release ready", int'(prod_ready), 1);
        len = 8'd2;
        send(-1); send(-2);
        chk("after reset frame acc_o", $signed(acc), -3);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
